// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the OV7670 register-table configuration sequencer.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    S_PWR,
    S_FETCH,
    S_REQ,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_FAIL
  } state_t;

  // Register address that turns a table entry into a pause instead of a write
  localparam logic [7:0] DLY_MARK = 8'hFF;

  localparam int unsigned ADDR_MSB = 15;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;

  localparam int unsigned ENTRY_W = 16;
  localparam int unsigned CNT_W   = 20;

endpackage

// File: rtl/ov7670_reg_lut.sv
// Camera register table ROM; the board wrapper supplies the contents, entry 0 in the LSBs.
module ov7670_reg_lut
  import cam_cfg_pkg::*;
#(
  parameter int unsigned            DEPTH = 168,
  parameter logic [DEPTH*16-1:0]    TABLE = '0
) (
  input  logic [7:0]         lut_index,
  output logic [ENTRY_W-1:0] lut_data
);

  // Out-of-range reads return a delay marker so a stray fetch never writes the bus
  always_comb begin
    lut_data = {DLY_MARK, 8'h00};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(lut_index) == i) lut_data = TABLE[i*ENTRY_W +: ENTRY_W];
    end
  end

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Walks the camera register table after power-up, issuing one SCCB write per entry
// with delay entries, NACK retry and a per-transaction watchdog.
module ov7670_cfg_seq
  import cam_cfg_pkg::*;
#(
  parameter int unsigned PWR_DLY_CYCLES = 1_000_000,
  parameter logic [7:0]  LUT_SIZE       = 8'd168,
  parameter int unsigned DLY_CYCLES     = 50_000,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  output logic [7:0]         lut_index,
  input  logic [ENTRY_W-1:0] lut_data,
  output logic               i2c_req,
  output logic [7:0]         i2c_addr,
  output logic [7:0]         i2c_wdata,
  input  logic               i2c_done,
  input  logic               i2c_nack,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_DLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'(DLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST = 2'(RETRY_MAX);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       retry, retry_n;
  logic [7:0]       index_n, addr_n, wdata_n;
  logic             req_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWR;
      cnt       <= '0;
      retry     <= '0;
      lut_index <= '0;
      i2c_addr  <= '0;
      i2c_wdata <= '0;
      i2c_req   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      lut_index <= index_n;
      i2c_addr  <= addr_n;
      i2c_wdata <= wdata_n;
      i2c_req   <= req_n;
    end
  end

  // One counter serves power-up wait, delay entries and the watchdog
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry;
    index_n = lut_index;
    addr_n  = i2c_addr;
    wdata_n = i2c_wdata;
    req_n   = 1'b0;
    unique case (state)
      S_PWR: begin
        if (cnt == PWR_LAST) begin
          cnt_n   = '0;
          index_n = '0;
          state_n = S_FETCH;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_FETCH: begin
        cnt_n = '0;
        if (lut_index == LUT_SIZE) begin
          state_n = S_DONE;
        end else if (lut_data[ADDR_MSB:ADDR_LSB] == DLY_MARK) begin
          state_n = S_DELAY;
        end else begin
          addr_n  = lut_data[ADDR_MSB:ADDR_LSB];
          wdata_n = lut_data[DATA_MSB:0];
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        req_n   = 1'b1;
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle takes precedence over the timeout
        if (i2c_done && !i2c_nack) begin
          retry_n = '0;
          index_n = lut_index + 8'd1;
          state_n = S_FETCH;
        end else if (i2c_done || cnt == TMO_LAST) begin
          if (retry < RETRY_LAST) begin
            retry_n = retry + 2'd1;
            state_n = S_REQ;
          end else begin
            state_n = S_FAIL;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DELAY: begin
        if (cnt == DLY_LAST) begin
          cnt_n   = '0;
          index_n = lut_index + 8'd1;
          state_n = S_FETCH;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE, S_FAIL: begin
        if (cfg_start) begin
          index_n = '0;
          retry_n = '0;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_PWR;
    endcase
  end

  assign cfg_done = (state == S_DONE);
  assign cfg_err  = (state == S_FAIL);
  assign cfg_busy = !(cfg_done || cfg_err);

endmodule
